// File: rtl/block_mult.sv
`default_nettype none
// ============================================================================
// block_mult : JxK by KxJ signed block multiply on one shared MAC unit
// Revision   : 1.0
// ============================================================================
module block_mult #(
  parameter int DATA_W = 16,
  parameter int J      = 4,
  parameter int K      = 4,
  parameter int ACC_W  = 2*DATA_W+4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [J*K*DATA_W-1:0]     block_a,
  input  logic [K*J*DATA_W-1:0]     block_b,
  output logic                      busy,
  output logic                      done,
  output logic [J*J*ACC_W-1:0]      block_c
);

  localparam int JW = (J > 1) ? $clog2(J) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2*DATA_W;
  localparam logic [JW-1:0] J_LAST = JW'(J-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MAC  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [JW-1:0]            i_q, i_d, j_q, j_d;
  logic [KW-1:0]            k_q, k_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [J*K*DATA_W-1:0]    a_q;
  logic [K*J*DATA_W-1:0]    b_q;
  logic [ACC_W-1:0]         c_q [J*J];
  logic                     done_q, done_d;
  logic                     load, wr_en, last;

  logic signed [DATA_W-1:0] a_el [J][K];
  logic signed [DATA_W-1:0] b_el [K][J];
  logic signed [DATA_W-1:0] a_sel, b_sel;
  logic signed [PW-1:0]     prod;
  logic [ACC_W-1:0]         prod_ext, sum;

  for (genvar r = 0; r < J; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign a_el[r][c] = a_q[(r*K+c)*DATA_W +: DATA_W];
      assign b_el[c][r] = b_q[(c*J+r)*DATA_W +: DATA_W];
    end
  end

  // Single shared multiplier and adder
  assign a_sel = a_el[i_q][k_q];
  assign b_sel = b_el[k_q][j_q];
  assign prod  = PW'(a_sel) * PW'(b_sel);

  if (ACC_W >= PW) begin : g_sext
    assign prod_ext = ACC_W'(prod);
  end else begin : g_trunc
    assign prod_ext = prod[ACC_W-1:0];
  end

  if (K == 1) begin : g_k1
    assign sum = prod_ext;
  end else begin : g_kn
    assign sum = acc_q + prod_ext;
  end

  assign load = (state_q == S_IDLE) && start;
  assign last = (i_q == J_LAST) && (j_q == J_LAST) && (k_q == K_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (last)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_MAC);
    done = done_q;
  end

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    acc_d  = acc_q;
    wr_en  = 1'b0;
    done_d = 1'b0;
    if (load) begin
      i_d   = '0;
      j_d   = '0;
      k_d   = '0;
      acc_d = '0;
    end else if (state_q == S_MAC) begin
      if (k_q == K_LAST) begin
        wr_en  = 1'b1;
        acc_d  = '0;
        k_d    = '0;
        done_d = last;
        if (j_q == J_LAST) begin
          j_d = '0;
          i_d = (i_q == J_LAST) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end else begin
        acc_d = sum;
        k_d   = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      k_q    <= k_d;
      acc_q  <= acc_d;
      done_q <= done_d;
      if (load) begin
        a_q <= block_a;
        b_q <= block_b;
      end
    end
  end

  // Each result element only updates when the walk reaches its (i,j) slot
  for (genvar e = 0; e < J*J; e++) begin : g_c
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        c_q[e] <= '0;
      else if (wr_en && (i_q == JW'(e / J)) && (j_q == JW'(e % J)))
        c_q[e] <= sum;
    end
    assign block_c[e*ACC_W +: ACC_W] = c_q[e];
  end

endmodule
`default_nettype wire

// File: doc/block_mult.md
BLOCK_MULT -- requirements
Module: block_mult

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_W, default 16: operand element width, signed two's complement.
- J, default 4: rows of block A; rows and columns of block C.
- K, default 4: columns of block A; rows of block B.
- ACC_W, default 2*DATA_W+4: result element width.

REQ-002 Ports SHALL be as follows.
- clk  in  1: rising-edge clock.
- rst  in  1: reset.
- start  in  1: request a block multiply.
- block_a  in  J*K*DATA_W: JxK operand.
- block_b  in  K*J*DATA_W: KxJ operand.
- busy  out  1: multiply in progress.
- done  out  1: one-cycle completion pulse.
- block_c  out  J*J*ACC_W: JxJ product.

REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

REQ-004 All block buses SHALL be flattened row-major, with element [r][c] at index r*cols+c and element 0 at the LSBs.

Function
REQ-005 The state machine SHALL have two states: IDLE and MAC.

REQ-006 In IDLE, start=1 sampled at a rising edge (call it E0) SHALL:
- capture block_a and block_b into internal operand registers;
- clear counters i, j, k and the accumulator;
- set busy=1 and go to MAC.

REQ-007 Input buses SHALL be ignored after E0; upstream may change them freely while busy=1.

REQ-008 In MAC, each edge SHALL perform exactly one multiply-accumulate: acc += sext(a[i][k]) * sext(b[k][j]).
- The full 2*DATA_W signed product is sign-extended to ACC_W.
- Accumulation wraps modulo 2^ACC_W, with no saturation.

REQ-009 Counter order SHALL be k innermost, then j, then i.

REQ-010 When k==K-1, the edge SHALL write acc+product into block_c[i][j], clear acc, set k=0 and advance j. When j wraps, j=0 and i advances.

REQ-011 The MAC edge at i=J-1, j=J-1, k=K-1 (edge E_N, N=J*J*K) SHALL:
- write the last element;
- return to IDLE;
- clear busy;
- set done=1.

REQ-012 done SHALL be high for exactly one cycle, from E_N to E_N+1, and be cleared at E_N+1 unconditionally.

REQ-013 start=1 during the done cycle SHALL be accepted at E_N+1, giving back-to-back throughput of one block every N+1 cycles.

REQ-014 start while busy=1 SHALL be ignored, with no effect on counters, operands or outputs.

REQ-015 block_c SHALL hold its last written value until it is overwritten element-by-element by the next multiply.
- During a multiply, elements not yet rewritten keep their previous values.
- block_c is guaranteed complete only while done=1 or in IDLE after done.

REQ-016 With K=1, the accumulator SHALL be bypassed: each edge writes product directly.

REQ-017 Every output element SHALL be ACC_W wide; no truncation to DATA_W takes place inside this block.

REQ-018 A single signed multiplier and a single adder SHALL be instantiated; there SHALL be no per-element parallel multipliers.

Reset
REQ-019 rst=0 SHALL asynchronously force the following, at any time including mid-MAC:
- state=IDLE;
- busy=0, done=0;
- block_c all zeros;
- i=j=k=0, acc=0;
- operand registers to zero.

REQ-020 After rst rises, the first start SHALL be honoured on the first rising edge at which rst=1.

REQ-021 An aborted multiply SHALL produce no done pulse and leave no partial result.

Verification (J=K=2, DATA_W=8, ACC_W=20 unless noted)
REQ-022 Basic: A=[1,2;3,4], B=[5,6;7,8], start at E0.
- busy=1 over E0..E8.
- done=1 only between E8 and E9.
- C=[19,22;43,50].

REQ-023 Signed: A all 0xFF (-1), B all 0x02.
- C all -4 (0xFFFFC).

REQ-024 Wrap: DATA_W=8, ACC_W=8, A all 0x7F, B all 0x7F.
- Each element is 2*16129 mod 256 = 0x02.

REQ-025 Back-to-back and ignored start:
- start held high continuously: done pulses at E8, E17, E26.
- Operands changed at E3 with a start pulse at E3: no effect on the current result.

REQ-026 Reset mid-operation: rst=0 asserted between E4 and E5.
- busy, done and block_c are 0 immediately, without waiting for a clock edge.
- No done pulse appears.
- A new start after release yields the correct C in 8 MAC edges.

REQ-027 Random: 1000 random A/B with J=3, K=4, DATA_W=16.
- Compare against a reference model.
- Check the done-cycle count = 36.
